// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
// The sequencer drives strobes/selects; the datapath supplies IR fields.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [5:0]       alu_op;
  logic [3:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic             timeout;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_source,
    output i_or_d, mem_read, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output state, instr_done, retired,
    output illegal, timeout
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_source,
    input  i_or_d, mem_read, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  state, instr_done, retired,
    input  illegal, timeout
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory wait timeout, illegal-opcode halt and retired-instruction count.
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input logic clk,
  input logic reset,
  multicycle_control_fsm_if.master bus
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT_MAX);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] ALU_ADD = 6'b100011;
  localparam logic [5:0] ALU_SUB = 6'b000100;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    HALT     = 4'd14
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             retire;
  logic             mem_st;
  logic             rdy;

  logic dec_jr, dec_r, dec_mem, dec_i, dec_beq, dec_jal;

  assign rdy     = bus.mem_ready;
  assign dec_jr  = (bus.opcode == OP_R) && (bus.funct == FN_JR);
  assign dec_r   = (bus.opcode == OP_R) && (bus.funct != FN_JR);
  assign dec_mem = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
  assign dec_i   = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ANDI);
  assign dec_beq = (bus.opcode == OP_BEQ);
  assign dec_jal = (bus.opcode == OP_JAL);

  assign mem_st = (state_q == FETCH) || (state_q == MEM_RD) ||
                  (state_q == MEM_WR);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (rdy) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          dec_jr:  state_d = JR;
          dec_r:   state_d = R_EXEC;
          dec_mem: state_d = MEM_ADDR;
          dec_i:   state_d = I_EXEC;
          dec_beq: state_d = BRANCH;
          dec_jal: state_d = JAL;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: state_d = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (rdy) state_d = MEM_WB;
      MEM_WR:   if (rdy) retire = 1'b1;
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      MEM_WB, R_WB, I_WB,
      BRANCH, JAL, JR: retire = 1'b1;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
    // ready in the final wait cycle still completes the access
    if (mem_st && !rdy) begin
      if (wait_q == WAIT_MAX) begin
        state_d   = HALT;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    if (retire) begin
      state_d   = FETCH;
      retired_d = retired_q + 1'b1;
    end
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  logic       pc_write, pc_write_cond, i_or_d;
  logic       mem_read, mem_write, ir_write;
  logic       reg_write, alu_src_a;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [5:0] alu_op;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 6'b000000;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: alu_src_a = 1'b1;
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = bus.opcode;
      end
      I_WB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_source     = pc_source;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.state         = state_q;
  assign bus.instr_done    = retire;
  assign bus.retired       = retired_q;
  assign bus.illegal       = illegal_q;
  assign bus.timeout       = timeout_q;
endmodule
